// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Purpose  : Interrupt controller for the multi-cycle CPU. Synchronises and
//            edge-detects one NMI and NUM_IRQ maskable request lines, keeps
//            per-source pending / in-service state and presents a single
//            prioritised request to the control FSM at instruction-fetch
//            boundaries, completed by an int_ack / eoi handshake.
// Ports    :
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   nmi          in   1        non-maskable request (async, rising edge)
//   irq          in   NUM_IRQ  maskable requests (async, rising edge per bit)
//   int_disable  in   1        global maskable disable (does not affect NMI)
//   mask_we      in   1        mask register write strobe
//   mask_wdata   in   NUM_IRQ  new mask value, 1 = channel masked
//   cpu_state    in   STATE_W  CPU control-FSM state
//   int_ack      in   1        CPU accepts the presented request
//   eoi          in   1        end-of-interrupt pulse (RETI)
//   eoi_nmi      in   1        eoi targets NMI handler (1) or maskable (0)
//   int_req      out  1        request to the CPU
//   int_nmi      out  1        presented request is the NMI
//   int_vec      out  VEC_W    presented maskable channel (0 for NMI)
//   pending      out  NUM_IRQ  latched pending bits
//   in_service   out  1        maskable handler active
//   nmi_active   out  1        NMI handler active
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int VEC_W       = 3,
  parameter int STATE_W     = 4,
  parameter int FETCH_STATE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nmi,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_disable,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [STATE_W-1:0] cpu_state,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               eoi_nmi,
  output logic               int_req,
  output logic               int_nmi,
  output logic [VEC_W-1:0]   int_vec,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic               nmi_active
);

  localparam logic [STATE_W-1:0] C_FETCH = STATE_W'(FETCH_STATE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Synchroniser and edge-detect flops
  logic               nmi_s1_q, nmi_s2_q, nmi_prev_q;
  logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q, irq_prev_q;

  // Architectural state
  state_t             state_q, state_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               in_service_q, in_service_d;
  logic               nmi_active_q, nmi_active_d;
  logic               req_nmi_q, req_nmi_d;
  logic [VEC_W-1:0]   req_vec_q, req_vec_d;

  // Combinational helpers
  logic               nmi_edge;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] irq_ready;
  logic               irq_found;
  logic [VEC_W-1:0]   irq_sel;
  logic               irq_cand;
  logic               nmi_cand;
  logic               at_fetch;
  logic [NUM_IRQ-1:0] vec_onehot;
  logic               mask_hits_vec;
  logic               ack_nmi;
  logic               ack_irq;

  assign nmi_edge = nmi_s2_q & ~nmi_prev_q;
  assign irq_edge = irq_s2_q & ~irq_prev_q;

  // Selection always looks at the registered mask, so a mask write in the
  // same cycle only takes effect from the following cycle.
  assign irq_ready = pending_q & ~mask_q;

  // Lowest-index ready channel: scanning downward lets the lowest hit win.
  always_comb begin
    irq_found = 1'b0;
    irq_sel   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_ready[i]) begin
        irq_found = 1'b1;
        irq_sel   = VEC_W'(i);
      end
    end
  end

  // No maskable nesting, and no maskable request while the NMI handler runs.
  assign irq_cand = irq_found & ~int_disable & ~in_service_q & ~nmi_active_q;
  // The NMI may preempt a running maskable handler.
  assign nmi_cand = nmi_pend_q & ~nmi_active_q;
  assign at_fetch = (cpu_state == C_FETCH);

  assign vec_onehot    = NUM_IRQ'(1) << req_vec_q;
  assign mask_hits_vec = |(mask_wdata & vec_onehot);

  // Request FSM
  always_comb begin
    state_d   = state_q;
    req_nmi_d = req_nmi_q;
    req_vec_d = req_vec_q;
    ack_nmi   = 1'b0;
    ack_irq   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (at_fetch && (nmi_cand || irq_cand)) begin
          state_d   = ST_REQ;
          req_nmi_d = nmi_cand;
          req_vec_d = nmi_cand ? '0 : irq_sel;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_d = ST_IDLE;
          ack_nmi = req_nmi_q;
          ack_irq = ~req_nmi_q;
        end else if (!req_nmi_q && (int_disable || (mask_we && mask_hits_vec))) begin
          // Withdraw a maskable request that is no longer allowed; pending
          // stays set so it can be presented again later.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending / active bookkeeping. A new edge wins over an ack-clear on the
  // same bit; an ack setting an active flag wins over a same-cycle eoi.
  always_comb begin
    nmi_pend_d   = nmi_edge | (nmi_pend_q & ~ack_nmi);
    pending_d    = irq_edge | (pending_q & ~(ack_irq ? vec_onehot : '0));
    mask_d       = mask_we ? mask_wdata : mask_q;
    in_service_d = ack_irq | (in_service_q & ~(eoi & ~eoi_nmi));
    nmi_active_d = ack_nmi | (nmi_active_q & ~(eoi & eoi_nmi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_s1_q     <= 1'b0;
      nmi_s2_q     <= 1'b0;
      nmi_prev_q   <= 1'b0;
      irq_s1_q     <= '0;
      irq_s2_q     <= '0;
      irq_prev_q   <= '0;
      state_q      <= ST_IDLE;
      nmi_pend_q   <= 1'b0;
      pending_q    <= '0;
      mask_q       <= '1;
      in_service_q <= 1'b0;
      nmi_active_q <= 1'b0;
      req_nmi_q    <= 1'b0;
      req_vec_q    <= '0;
    end else begin
      nmi_s1_q     <= nmi;
      nmi_s2_q     <= nmi_s1_q;
      nmi_prev_q   <= nmi_s2_q;
      irq_s1_q     <= irq;
      irq_s2_q     <= irq_s1_q;
      irq_prev_q   <= irq_s2_q;
      state_q      <= state_d;
      nmi_pend_q   <= nmi_pend_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      nmi_active_q <= nmi_active_d;
      req_nmi_q    <= req_nmi_d;
      req_vec_q    <= req_vec_d;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign int_nmi    = int_req & req_nmi_q;
  assign int_vec    = (int_req && !req_nmi_q) ? req_vec_q : '0;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign nmi_active = nmi_active_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Self-checking bench for irq_controller. Expected requests are
//            queued when stimulus is applied and compared when the DUT
//            raises int_req; other state is compared via chk().
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_controller;

  localparam int NUM_IRQ = 8;
  localparam int VEC_W   = 3;
  localparam int STATE_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               nmi;
  logic [NUM_IRQ-1:0] irq;
  logic               int_disable;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [STATE_W-1:0] cpu_state;
  logic               int_ack;
  logic               eoi;
  logic               eoi_nmi;
  logic               int_req;
  logic               int_nmi;
  logic [VEC_W-1:0]   int_vec;
  logic [NUM_IRQ-1:0] pending;
  logic               in_service;
  logic               nmi_active;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries are {int_nmi, int_vec}
  logic [VEC_W:0] sb_q[$];

  irq_controller #(
    .NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W), .STATE_W(STATE_W), .FETCH_STATE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .nmi(nmi), .irq(irq),
    .int_disable(int_disable), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .cpu_state(cpu_state), .int_ack(int_ack), .eoi(eoi), .eoi_nmi(eoi_nmi),
    .int_req(int_req), .int_nmi(int_nmi), .int_vec(int_vec),
    .pending(pending), .in_service(in_service), .nmi_active(nmi_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_irq(input int ch);
    irq[ch] = 1'b1;
    tick();
    irq[ch] = 1'b0;
  endtask

  task automatic pulse_nmi();
    nmi = 1'b1;
    tick();
    nmi = 1'b0;
  endtask

  task automatic write_mask(input logic [NUM_IRQ-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi(input logic is_nmi);
    eoi     = 1'b1;
    eoi_nmi = is_nmi;
    tick();
    eoi     = 1'b0;
    eoi_nmi = 1'b0;
  endtask

  task automatic expect_req(input logic is_nmi, input logic [VEC_W-1:0] vec);
    sb_q.push_back({is_nmi, vec});
  endtask

  // Wait (bounded) for int_req, then pop and compare the oldest expectation.
  task automatic await_req(input string tag);
    logic [VEC_W:0] exp_v;
    int             waited;
    waited = 0;
    while (!int_req && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_req_seen"}, {31'd0, int_req}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_v = sb_q.pop_front();
      chk({tag, "_nmi_vec"}, {28'd0, int_nmi, int_vec}, {28'd0, exp_v});
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    nmi         = 1'b0;
    irq         = '0;
    int_disable = 1'b0;
    mask_we     = 1'b0;
    mask_wdata  = '0;
    cpu_state   = '0;
    int_ack     = 1'b0;
    eoi         = 1'b0;
    eoi_nmi     = 1'b0;

    // ---------------- Reset state ----------------
    ticks(2);
    chk("rst_outputs", {21'd0, int_req, int_nmi, int_vec, in_service, nmi_active},
        32'd0);
    chk("rst_pending", {24'd0, pending}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- NMI with all channels masked ----------------
    nmi = 1'b1;
    tick();                       // edge k samples nmi high
    nmi = 1'b0;
    ticks(2);                     // after edge k+2
    chk("nmi_lat_k2", {31'd0, int_req}, 32'd0);
    expect_req(1'b1, 3'd0);
    tick();                       // after edge k+3
    chk("nmi_lat_k3", {31'd0, int_req}, 32'd1);
    await_req("nmi");
    do_ack();
    chk("nmi_ack_req", {31'd0, int_req}, 32'd0);
    chk("nmi_active_set", {31'd0, nmi_active}, 32'd1);
    do_eoi(1'b1);
    chk("nmi_active_clr", {31'd0, nmi_active}, 32'd0);

    // ---------------- Priority: irq[5] and irq[2] together ----------------
    write_mask('0);
    irq[5] = 1'b1;
    irq[2] = 1'b1;
    tick();
    irq = '0;
    expect_req(1'b0, 3'd2);
    expect_req(1'b0, 3'd5);
    await_req("prio_first");
    do_ack();
    chk("prio_in_service", {31'd0, in_service}, 32'd1);
    ticks(4);
    chk("prio_no_nest", {31'd0, int_req}, 32'd0);
    do_eoi(1'b0);
    await_req("prio_second");
    do_ack();
    do_eoi(1'b0);
    chk("prio_pending_empty", {24'd0, pending}, 32'd0);

    // ---------------- Boundary gating ----------------
    cpu_state = 4'd3;
    pulse_irq(1);
    ticks(6);
    chk("gate_no_req", {31'd0, int_req}, 32'd0);
    chk("gate_pending", {24'd0, pending}, 32'h02);
    expect_req(1'b0, 3'd1);
    cpu_state = 4'd0;
    tick();
    chk("gate_req_rise", {31'd0, int_req}, 32'd1);
    await_req("gate");
    do_ack();
    do_eoi(1'b0);

    // ---------------- Withdraw by mask write ----------------
    expect_req(1'b0, 3'd4);
    pulse_irq(4);
    await_req("wd_first");
    write_mask(8'h10);
    chk("wd_req_drop", {31'd0, int_req}, 32'd0);
    chk("wd_pending_kept", {24'd0, pending}, 32'h10);
    ticks(3);
    chk("wd_stays_idle", {31'd0, int_req}, 32'd0);
    expect_req(1'b0, 3'd4);
    write_mask('0);
    await_req("wd_again");
    do_ack();
    do_eoi(1'b0);

    // ---------------- NMI preemption ----------------
    expect_req(1'b0, 3'd3);
    pulse_irq(3);
    await_req("pre_irq3");
    do_ack();
    expect_req(1'b1, 3'd0);
    pulse_nmi();
    await_req("pre_nmi");
    do_ack();
    chk("pre_both_active", {30'd0, nmi_active, in_service}, 32'd3);
    pulse_irq(0);
    ticks(5);
    chk("pre_irq0_held", {31'd0, int_req}, 32'd0);
    chk("pre_irq0_pending", {24'd0, pending}, 32'h01);
    do_eoi(1'b0);
    ticks(4);
    chk("pre_after_eoi1", {31'd0, int_req}, 32'd0);
    expect_req(1'b0, 3'd0);
    do_eoi(1'b1);
    await_req("pre_irq0");
    do_ack();
    do_eoi(1'b0);

    // ---------------- Set edge coincides with ack-clear ----------------
    expect_req(1'b0, 3'd6);
    pulse_irq(6);
    await_req("coll_first");
    irq[6] = 1'b1;
    tick();                       // edge k samples irq[6]
    irq[6] = 1'b0;
    tick();                       // edge k+1: edge now visible internally
    int_ack = 1'b1;
    tick();                       // edge k+2: ack-clear and set together
    int_ack = 1'b0;
    chk("coll_pending6", {24'd0, pending}, 32'h40);
    chk("coll_in_service", {31'd0, in_service}, 32'd1);
    expect_req(1'b0, 3'd6);
    do_eoi(1'b0);
    await_req("coll_again");

    // ---------------- Asynchronous reset during REQ ----------------
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'd0, int_req}, 32'd0);
    chk("rst_pending_clr", {24'd0, pending}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_irq(1);
    ticks(6);
    chk("rst_mask_ones_req", {31'd0, int_req}, 32'd0);
    chk("rst_mask_ones_pend", {24'd0, pending}, 32'h02);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
